// File: rtl/fc_bram_seq.sv
// FC layer BRAM sequencer: streams each sample's input vector from BRAM into the FC
// core one element per cycle, then writes the zero-padded result vector back to BRAM.
module fc_bram_seq #(
   parameter int                     DIM_INPUT   = 96,
   parameter int                     DIM_OUTPUT  = 8,
   parameter int                     INPUT_W     = 16,
   parameter int                     OUTPUT_W    = 8,
   parameter int                     BRAM_DAT_W  = 64,
   parameter int                     BRAM_ADDR_W = 32,
   parameter int                     MAX_BATCH   = 1023,
   parameter logic [BRAM_ADDR_W-1:0] LOAD_BASE   = 'h0000,
   parameter logic [BRAM_ADDR_W-1:0] STORE_BASE  = 'h3400
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic                                abort,
   input  logic [$clog2(MAX_BATCH+1)-1:0]      batch_num,
   output logic                                busy,
   output logic                                done,
   output logic                                err,
   output logic                                fc_in_vld,
   output logic [INPUT_W-1:0]                  fc_in_dat,
   input  logic                                fc_out_vld,
   input  logic [DIM_OUTPUT*OUTPUT_W-1:0]      fc_out_dat,
   output logic [BRAM_ADDR_W-1:0]              bram_addr,
   output logic                                bram_en,
   output logic [BRAM_DAT_W/8-1:0]             bram_we,
   output logic [BRAM_DAT_W-1:0]               bram_din,
   input  logic [BRAM_DAT_W-1:0]               bram_dout
);

   localparam int BW       = $clog2(MAX_BATCH+1);
   localparam int LANES    = BRAM_DAT_W / INPUT_W;
   localparam int WIN      = (DIM_INPUT + LANES - 1) / LANES;
   localparam int OUT_BITS = DIM_OUTPUT * OUTPUT_W;
   localparam int WOUT     = (OUT_BITS + BRAM_DAT_W - 1) / BRAM_DAT_W;
   localparam int RES_W    = WOUT * BRAM_DAT_W;
   localparam int ADDR_INC = BRAM_DAT_W / 8;
   localparam int PH_W     = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int CYC_W    = $clog2(DIM_INPUT + 2);
   localparam int WC_W     = $clog2(WIN + 1);
   localparam int SW_W     = $clog2(WOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT,
      S_STORE,
      S_FIN
   } state_t;

   state_t                 state;
   logic [BW-1:0]          batch;
   logic [BW-1:0]          smp_cnt;
   logic [CYC_W-1:0]       cyc;
   logic [PH_W-1:0]        ph;
   logic [PH_W-1:0]        ph_d;
   logic [PH_W-1:0]        ph_nxt;
   logic [WC_W-1:0]        wrd;
   logic [SW_W-1:0]        swc;
   logic [BRAM_ADDR_W-1:0] ld_ptr;
   logic [BRAM_ADDR_W-1:0] st_ptr;
   logic [RES_W-1:0]       res;
   logic [RES_W-1:0]       fc_pad;
   logic [INPUT_W-1:0]     lane_dat;

   // ph is the lane phase of the current LOAD cycle; a new word is read whenever it wraps.
   // ph_d is the lane of the element being captured, one cycle behind the read.
   assign ph_nxt = (ph == PH_W'(LANES - 1)) ? '0 : ph + PH_W'(1);
   assign fc_pad = RES_W'(fc_out_dat);

   always_comb begin
      lane_dat = '0;
      for (int i = 0; i < LANES; i++) begin
         if (ph_d == PH_W'(i)) lane_dat = bram_dout[i*INPUT_W +: INPUT_W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         fc_in_vld <= 1'b0;
         fc_in_dat <= '0;
         bram_en   <= 1'b0;
         bram_we   <= '0;
         bram_din  <= '0;
         bram_addr <= '0;
         batch     <= '0;
         smp_cnt   <= '0;
         cyc       <= '0;
         ph        <= '0;
         ph_d      <= '0;
         wrd       <= '0;
         swc       <= '0;
         ld_ptr    <= '0;
         st_ptr    <= '0;
         res       <= '0;
      end else begin
         bram_en   <= 1'b0;
         bram_we   <= '0;
         fc_in_vld <= 1'b0;
         done      <= 1'b0;
         if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     batch   <= batch_num;
                     smp_cnt <= '0;
                     err     <= 1'b0;
                     st_ptr  <= STORE_BASE;
                     busy    <= 1'b1;
                     if (batch_num == '0) begin
                        state <= S_FIN;
                     end else begin
                        state     <= S_LOAD;
                        bram_en   <= 1'b1;
                        bram_addr <= LOAD_BASE;
                        ld_ptr    <= LOAD_BASE + BRAM_ADDR_W'(ADDR_INC);
                        cyc       <= '0;
                        ph        <= '0;
                        wrd       <= WC_W'(1);
                     end
                  end
               end
               S_LOAD: begin
                  cyc  <= cyc + CYC_W'(1);
                  ph   <= ph_nxt;
                  ph_d <= ph;
                  if (cyc >= CYC_W'(1) && cyc <= CYC_W'(DIM_INPUT)) begin
                     fc_in_vld <= 1'b1;
                     fc_in_dat <= lane_dat;
                  end
                  if (ph_nxt == '0 && wrd < WC_W'(WIN)) begin
                     bram_en   <= 1'b1;
                     bram_addr <= ld_ptr;
                     ld_ptr    <= ld_ptr + BRAM_ADDR_W'(ADDR_INC);
                     wrd       <= wrd + WC_W'(1);
                  end
                  if (cyc == CYC_W'(DIM_INPUT + 1)) state <= S_WAIT;
               end
               S_WAIT: begin
                  if (fc_out_vld) begin
                     bram_din  <= fc_pad[BRAM_DAT_W-1:0];
                     res       <= fc_pad >> BRAM_DAT_W;
                     bram_en   <= 1'b1;
                     bram_we   <= '1;
                     bram_addr <= st_ptr;
                     st_ptr    <= st_ptr + BRAM_ADDR_W'(ADDR_INC);
                     swc       <= SW_W'(1);
                     state     <= S_STORE;
                  end
               end
               S_STORE: begin
                  if (swc < SW_W'(WOUT)) begin
                     bram_din  <= res[BRAM_DAT_W-1:0];
                     res       <= res >> BRAM_DAT_W;
                     bram_en   <= 1'b1;
                     bram_we   <= '1;
                     bram_addr <= st_ptr;
                     st_ptr    <= st_ptr + BRAM_ADDR_W'(ADDR_INC);
                     swc       <= swc + SW_W'(1);
                  end else begin
                     smp_cnt <= smp_cnt + BW'(1);
                     if (smp_cnt + BW'(1) == batch) begin
                        state <= S_FIN;
                     end else begin
                        state     <= S_LOAD;
                        bram_en   <= 1'b1;
                        bram_addr <= ld_ptr;
                        ld_ptr    <= ld_ptr + BRAM_ADDR_W'(ADDR_INC);
                        cyc       <= '0;
                        ph        <= '0;
                        wrd       <= WC_W'(1);
                     end
                  end
               end
               S_FIN: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
         // A result outside WAIT is a protocol error; it also overrides the clear on start.
         if (fc_out_vld && state != S_WAIT) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fc_bram_seq.sv
// Bench for fc_bram_seq: random BRAM contents and FC results, a queue-based scoreboard
// for reads, streamed elements and writes, plus directed abort/error/reset scenarios.
module tb_fc_bram_seq;

   localparam int          DI    = 10;
   localparam int          DO    = 10;
   localparam int          IW    = 16;
   localparam int          OW    = 8;
   localparam int          DW    = 64;
   localparam int          AW    = 32;
   localparam int          MB    = 1023;
   localparam logic [31:0] LB    = 32'h0000;
   localparam logic [31:0] SB    = 32'h3400;
   localparam int          BW    = $clog2(MB + 1);
   localparam int          LANES = DW / IW;
   localparam int          WIN   = (DI + LANES - 1) / LANES;
   localparam int          WOUT  = (DO * OW + DW - 1) / DW;

   logic              clk, rst, start, abort;
   logic [BW-1:0]     batch_num;
   logic              busy, done, err, fc_in_vld, fc_out_vld, bram_en;
   logic [IW-1:0]     fc_in_dat;
   logic [DO*OW-1:0]  fc_out_dat;
   logic [AW-1:0]     bram_addr;
   logic [DW/8-1:0]   bram_we;
   logic [DW-1:0]     bram_din, bram_dout;

   logic [DW-1:0]     mem [0:255];
   logic [IW-1:0]     exp_in_q[$];
   logic [AW-1:0]     exp_rd_q[$];
   logic [AW+DW-1:0]  exp_wr_q[$];

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int elem_cnt = 0;
   int core_smp = 0;
   int wait_cnt = 0;
   bit core_clr = 0;
   bit glitch_req = 0;

   fc_bram_seq #(
      .DIM_INPUT(DI), .DIM_OUTPUT(DO), .INPUT_W(IW), .OUTPUT_W(OW),
      .BRAM_DAT_W(DW), .BRAM_ADDR_W(AW), .MAX_BATCH(MB),
      .LOAD_BASE(LB), .STORE_BASE(SB)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .batch_num(batch_num),
      .busy(busy), .done(done), .err(err),
      .fc_in_vld(fc_in_vld), .fc_in_dat(fc_in_dat),
      .fc_out_vld(fc_out_vld), .fc_out_dat(fc_out_dat),
      .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
      .bram_din(bram_din), .bram_dout(bram_dout)
   );

   // clock / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endfunction

   // BRAM: one-cycle read latency, output held while en is low
   initial begin : bram_model
      logic [DW-1:0] rd_word;
      bram_dout = '0;
      forever begin
         @(posedge clk);
         if (bram_en && bram_we == '0) begin
            rd_word = mem[bram_addr[10:3]];
            #1 bram_dout = rd_word;
         end
      end
   end

   // FC core model: after DI elements, return a random result 1..4 cycles into WAIT
   initial begin : core_model
      logic [95:0]        rnd;
      logic [WOUT*DW-1:0] pad;
      logic [AW-1:0]      wa;
      fc_out_vld = 1'b0;
      fc_out_dat = '0;
      forever begin
         @(negedge clk);
         fc_out_vld = 1'b0;
         if (core_clr) begin
            elem_cnt = 0;
            wait_cnt = 0;
            core_smp = 0;
            core_clr = 0;
         end else if (fc_in_vld) begin
            elem_cnt++;
            if (glitch_req && elem_cnt == 4) begin
               rnd = {$urandom(), $urandom(), $urandom()};
               fc_out_vld = 1'b1;
               fc_out_dat = rnd[DO*OW-1:0];
               glitch_req = 0;
            end
            if (elem_cnt == DI) begin
               elem_cnt = 0;
               wait_cnt = $urandom_range(1, 4);
            end
         end else if (wait_cnt > 0) begin
            wait_cnt--;
            if (wait_cnt == 0) begin
               rnd = {$urandom(), $urandom(), $urandom()};
               fc_out_vld = 1'b1;
               fc_out_dat = rnd[DO*OW-1:0];
               pad = (WOUT*DW)'(rnd[DO*OW-1:0]);
               for (int w = 0; w < WOUT; w++) begin
                  wa = SB + 32'((core_smp * WOUT + w) * (DW / 8));
                  exp_wr_q.push_back({wa, DW'(pad >> (w * DW))});
               end
               core_smp++;
            end
         end
      end
   end

   // scoreboard monitor
   initial begin : monitor
      logic [AW+DW-1:0] ew;
      logic [DW/8-1:0]  all_we;
      all_we = '1;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (fc_in_vld) begin
               chk("in_q_nonempty", 64'(exp_in_q.size() != 0), 64'd1);
               if (exp_in_q.size() != 0) chk("in_dat", 64'(fc_in_dat), 64'(exp_in_q.pop_front()));
            end
            if (bram_en && bram_we == '0) begin
               chk("rd_q_nonempty", 64'(exp_rd_q.size() != 0), 64'd1);
               if (exp_rd_q.size() != 0) chk("rd_addr", 64'(bram_addr), 64'(exp_rd_q.pop_front()));
            end
            if (bram_en && bram_we != '0) begin
               chk("wr_we", 64'(bram_we), 64'(all_we));
               chk("wr_q_nonempty", 64'(exp_wr_q.size() != 0), 64'd1);
               if (exp_wr_q.size() != 0) begin
                  ew = exp_wr_q.pop_front();
                  chk("wr_addr", 64'(bram_addr), 64'(ew[AW+DW-1:DW]));
                  chk("wr_data", bram_din, ew[DW-1:0]);
               end
            end
            if (done) begin
               done_cnt++;
               chk("done_wr_drained", 64'(exp_wr_q.size()), 64'd0);
               chk("done_in_drained", 64'(exp_in_q.size()), 64'd0);
            end
         end
      end
   end

   // driver tasks
   task automatic prep(input int n);
      logic [DW-1:0] word;
      for (int s = 0; s < n; s++) begin
         for (int w = 0; w < WIN; w++) exp_rd_q.push_back(LB + 32'((s * WIN + w) * (DW / 8)));
         for (int k = 0; k < DI; k++) begin
            word = mem[s * WIN + k / LANES];
            exp_in_q.push_back(IW'(word >> ((k % LANES) * IW)));
         end
      end
   endtask

   task automatic issue_start(input int n);
      @(posedge clk); #1;
      start = 1'b1;
      batch_num = BW'(n);
      core_clr = 1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic flush();
      exp_in_q.delete();
      exp_rd_q.delete();
      exp_wr_q.delete();
   endtask

   task automatic run_batch(input int n, input bit glitch);
      int d0, t;
      prep(n);
      glitch_req = glitch;
      d0 = done_cnt;
      issue_start(n);
      @(negedge clk);
      chk("start_busy", 64'(busy), 64'd1);
      chk("start_err_clear", 64'(err), 64'd0);
      t = 0;
      while (done_cnt == d0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("done_seen", 64'(done_cnt - d0), 64'd1);
      repeat (3) @(negedge clk);
      chk("done_once", 64'(done_cnt - d0), 64'd1);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("err_after", 64'(err), 64'(glitch));
      chk("rd_drained", 64'(exp_rd_q.size()), 64'd0);
   endtask

   initial begin : main
      int d0, t;
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      batch_num = '0;
      for (int i = 0; i < 256; i++) mem[i] = {$urandom(), $urandom()};
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_in_vld", 64'(fc_in_vld), 64'd0);
      chk("rst_en", 64'(bram_en), 64'd0);
      chk("rst_we", 64'(bram_we), 64'd0);
      chk("rst_addr", 64'(bram_addr), 64'd0);
      chk("rst_din", bram_din, 64'd0);
      chk("rst_in_dat", 64'(fc_in_dat), 64'd0);

      run_batch(2, 0);
      run_batch(1, 1);
      run_batch(1, 0);

      // empty batch: FIN only, done two cycles after start
      d0 = done_cnt;
      issue_start(0);
      @(negedge clk);
      chk("b0_busy_fin", 64'(busy), 64'd1);
      chk("b0_done_early", 64'(done), 64'd0);
      @(negedge clk);
      chk("b0_busy_idle", 64'(busy), 64'd0);
      chk("b0_done", 64'(done), 64'd1);
      repeat (2) @(negedge clk);
      chk("b0_done_once", 64'(done_cnt - d0), 64'd1);

      // abort during sample 1 load
      prep(3);
      d0 = done_cnt;
      issue_start(3);
      t = 0;
      while (!(core_smp == 1 && elem_cnt == 3) && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("abort_reached", 64'(core_smp == 1 && elem_cnt == 3), 64'd1);
      @(posedge clk); #1;
      abort = 1'b1;
      core_clr = 1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_in_vld", 64'(fc_in_vld), 64'd0);
      chk("abort_en", 64'(bram_en), 64'd0);
      flush();
      repeat (5) @(negedge clk);
      chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
      run_batch(1, 0);

      // abort and start together in idle: no batch
      d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1;
      abort = 1'b1;
      batch_num = BW'(2);
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      chk("abort_start_busy", 64'(busy), 64'd0);
      repeat (6) @(negedge clk);
      chk("abort_start_done", 64'(done_cnt - d0), 64'd0);

      // reset in the middle of a batch
      prep(2);
      issue_start(2);
      repeat (15) @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      core_clr = 1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_in_vld", 64'(fc_in_vld), 64'd0);
      chk("mrst_en", 64'(bram_en), 64'd0);
      chk("mrst_addr", 64'(bram_addr), 64'd0);
      chk("mrst_in_dat", 64'(fc_in_dat), 64'd0);
      flush();
      repeat (3) @(negedge clk);

      for (int i = 0; i < 4; i++) run_batch($urandom_range(1, 5), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fc_bram_seq.md
Name: fc_bram_seq

Overview:
- Parametrised successor to the FC layer BRAM sequencer.
- Given `start` and a runtime batch count, streams each input sample from BRAM into the FC core one element per cycle, waits for the core result, and writes the packed output vector back to BRAM.
- Handles any lane count (`BRAM_DAT_W`/`INPUT_W`), multi-word output stores with zero padding, runtime batch size, abort, and a sticky protocol-error flag.
- Sits between the AXI-BRAM controller's shared port and the FC datapath; software control goes through `start`/`done`.

Parameters:
DIM_INPUT, 96, input elements per sample
DIM_OUTPUT, 8, output elements per sample
INPUT_W, 16, input element width; must divide BRAM_DAT_W
OUTPUT_W, 8, output element width
BRAM_DAT_W, 64, BRAM data width
BRAM_ADDR_W, 32, BRAM byte-address width
MAX_BATCH, 1023, maximum batch count; sets batch_num width BW=$clog2(MAX_BATCH+1)
LOAD_BASE, 'h0000, byte address of sample 0 input
STORE_BASE, 'h3400, byte address of sample 0 output

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; begins a batch when idle
abort  in  1  pulse; returns to IDLE from any state
batch_num  in  BW  samples to process; sampled on accepted start
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on batch completion
err  out  1  sticky protocol error; cleared by accepted start
fc_in_vld  out  1  input element valid
fc_in_dat  out  INPUT_W  input element
fc_out_vld  in  1  FC result valid (single-cycle pulse)
fc_out_dat  in  DIM_OUTPUT*OUTPUT_W  flattened result, element i at [i*OUTPUT_W +: OUTPUT_W]
bram_addr  out  BRAM_ADDR_W  byte address
bram_en  out  1  BRAM enable
bram_we  out  BRAM_DAT_W/8  byte write enable, all ones on write
bram_din  out  BRAM_DAT_W  write data
bram_dout  in  BRAM_DAT_W  read data; 1-cycle latency, held while en low

Behaviour:
- Derived constants:
  - LANES = BRAM_DAT_W/INPUT_W
  - WIN = ceil(DIM_INPUT/LANES) words per sample
  - WOUT = ceil(DIM_OUTPUT*OUTPUT_W/BRAM_DAT_W) words per sample
  - ADDR_INC = BRAM_DAT_W/8
- Memory layout:
  - Each sample starts on a fresh word. Unused tail lanes are ignored on read.
  - Input address = LOAD_BASE + (s*WIN+w)*ADDR_INC.
  - Output address = STORE_BASE + (s*WOUT+w)*ADDR_INC.
- Reset: state IDLE. `busy`, `done`, `err`, `fc_in_vld`, `bram_en`, `bram_we` = 0. `fc_in_dat`, `bram_din`, `bram_addr` = 0. Sample counter = 0.
- States and transitions:
  - IDLE: `start` latches `batch_num`, clears `err`. Goes to LOAD, or to FIN if `batch_num`==0 (no BRAM access). `start` is ignored when not IDLE.
  - LOAD:
    - With T0 = the first LOAD cycle, word w is read at cycle T0+w*LANES with `bram_en`=1 and `bram_we`=0. `bram_en`=0 on all other LOAD cycles.
    - Element k is registered out at T0+2+k with `fc_in_vld`=1, lane (k mod LANES), lane 0 = LSBs.
    - Exactly DIM_INPUT consecutive valid cycles per sample, then WAIT.
  - WAIT: `fc_out_vld` captures `fc_out_dat` into a WOUT*BRAM_DAT_W register; bits above DIM_OUTPUT*OUTPUT_W are zero. Then STORE.
  - STORE: one write per cycle, words 0..WOUT-1, LSB word first, `bram_en`=1 and `bram_we`=all ones. After the last word, increment the sample counter; go to FIN if it equals the latched batch, else LOAD.
  - FIN: `done`=1 for one cycle, then IDLE.
- Abort: any state goes to IDLE next cycle. `fc_in_vld`, `bram_en` and `bram_we` drop that cycle. `done` is not pulsed.
- Simultaneous `abort` and `start` in IDLE: abort wins; the batch is not started.
- Error: `fc_out_vld` in any state other than WAIT sets `err`; the data is ignored and the state is unchanged.
- Reset mid-operation returns to the reset values in the next cycle.
- `fc_out_vld` arriving in the same cycle the last element is sent is an error. The earliest legal arrival is the first WAIT cycle.

Test Plan:
- Defaults, batch_num=2, BRAM word k = {4{16'(k)}} -> reads at 0x0000..0x00B8 then 0x00C0..0x0178. 96 `fc_in_vld` cycles per sample, element k = k/4 within its sample's words. Writes at 0x3400 and 0x3408 carry the captured `fc_out_dat`. `done` pulses once.
- DIM_INPUT=10, INPUT_W=16 -> WIN=3. Sample 1 starts at 0x0018. Lanes 2–3 of word 2 are never presented. Exactly 10 valid cycles per sample.
- DIM_OUTPUT=10, OUTPUT_W=8 -> WOUT=2. Second write = {48'h0, elements 9:8}, written at STORE_BASE+8.
- batch_num=0 -> `done` pulses 2 cycles after `start`, no `bram_en` activity, `busy` high 1 cycle.
- `fc_out_vld` pulsed during LOAD -> `err`=1, no state change, later valid result stored normally. Next `start` clears `err`.
- `abort` mid-LOAD of sample 1 -> IDLE next cycle, `fc_in_vld`=0, no `done`. A following `start` with batch 1 reads from 0x0000 again.
